shift_op_sequencer: RTL and testbench

//  Front-end controller for the 16-bit left-only log shifter. Accepts shift requests
//  (SHL, SHR, ROL) over a valid/ready port and drives the shifter's shamt/in inputs.

---
 rtl/shift_seq_pkg.sv | 28 ++
 rtl/shift_op_sequencer.sv | 100 ++++++++++
 tb/tb_shift_op_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift-op sequencer: op and state encodings,
// datapath widths and the bit-reversal used to build SHR/ROL from a left shifter.
package shift_seq_pkg;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;

  typedef enum logic [1:0] {
    OP_SHL  = 2'b00,
    OP_SHR  = 2'b01,
    OP_ROL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS1,
    ST_PASS2,
    ST_DONE
  } state_e;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

endpackage

// File: rtl/shift_op_sequencer.sv
// Front-end controller for a shared left-only log shifter. SHR and ROL are
// built by reversing bits around the shifter, using one or two passes per op.
module shift_op_sequencer
  import shift_seq_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               io_req_valid,
  output logic               io_req_ready,
  input  logic [1:0]         io_req_op,
  input  logic [SHAMT_W-1:0] io_req_shamt,
  input  logic [WIDTH-1:0]   io_req_data,
  output logic               io_resp_valid,
  input  logic               io_resp_ready,
  output logic [WIDTH-1:0]   io_resp_data,
  output logic               io_resp_err,
  output logic [SHAMT_W-1:0] io_sh_shamt,
  output logic [WIDTH-1:0]   io_sh_in,
  input  logic [WIDTH-1:0]   io_sh_out
);

  localparam logic [SHAMT_W:0] WIDTH_EXT = (SHAMT_W+1)'(WIDTH);

  state_e             state, state_nxt;
  op_e                op_q;
  logic [SHAMT_W-1:0] n_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   acc;
  logic               err_q;
  logic [SHAMT_W:0]   comp_shamt;

  // Second ROL pass shifts by WIDTH-n; computed one bit wider so n never wraps early.
  assign comp_shamt = WIDTH_EXT - {1'b0, n_q};

  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinationally driven signal gets a default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (io_req_valid) state_nxt = ST_PASS1;
      ST_PASS1: state_nxt = (op_q == OP_ROL && n_q != '0) ? ST_PASS2 : ST_DONE;
      ST_PASS2: state_nxt = ST_DONE;
      ST_DONE:  if (io_resp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    io_req_ready  = (state == ST_IDLE);
    io_resp_valid = (state == ST_DONE);
    io_sh_shamt   = '0;
    io_sh_in      = '0;
    case (state)
      ST_PASS1: begin
        io_sh_shamt = n_q;
        io_sh_in    = (op_q == OP_SHR) ? bit_rev(data_q) : data_q;
      end
      ST_PASS2: begin
        io_sh_shamt = comp_shamt[SHAMT_W-1:0];
        io_sh_in    = bit_rev(data_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q   <= OP_SHL;
      n_q    <= '0;
      data_q <= '0;
      acc    <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io_req_valid) begin
            op_q   <= op_e'(io_req_op);
            n_q    <= io_req_shamt;
            data_q <= io_req_data;
            err_q  <= (io_req_op == OP_RSVD);
          end
        end
        ST_PASS1: acc <= (op_q == OP_SHR) ? bit_rev(io_sh_out) : io_sh_out;
        ST_PASS2: acc <= acc | bit_rev(io_sh_out);
        default: ;
      endcase
    end
  end

  assign io_resp_data = acc;
  assign io_resp_err  = err_q;

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Self-checking bench: the sequencer plus a behavioural left shifter, driven by
// directed and random requests compared against an arithmetic reference model.
module tb_shift_op_sequencer;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_shamt;
  logic [15:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_err;
  logic [3:0]  sh_shamt;
  logic [15:0] sh_in;
  logic [15:0] sh_out;

  int n_tests = 0;
  int n_fail  = 0;

  shift_op_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .io_req_valid  (req_valid),
    .io_req_ready  (req_ready),
    .io_req_op     (req_op),
    .io_req_shamt  (req_shamt),
    .io_req_data   (req_data),
    .io_resp_valid (resp_valid),
    .io_resp_ready (resp_ready),
    .io_resp_data  (resp_data),
    .io_resp_err   (resp_err),
    .io_sh_shamt   (sh_shamt),
    .io_sh_in      (sh_in),
    .io_sh_out     (sh_out)
  );

  // The shared shifter that sits beside the sequencer in the wrapper.
  assign sh_out = sh_in << sh_shamt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
    return r;
  endfunction

  function automatic logic [15:0] model(input int op, input int n, input logic [15:0] d);
    int x;
    x = int'(d);
    case (op)
      1:       return 16'(x >> n);
      2:       return 16'(((x << n) | (x >> (16 - n))) & 32'hFFFF);
      default: return 16'((x << n) & 32'hFFFF);
    endcase
  endfunction

  task automatic run_op(input int op, input int n, input logic [15:0] d, input int stall);
    int          lat;
    logic [15:0] exp_res;
    lat     = (op == 2 && n != 0) ? 3 : 2;
    exp_res = model(op, n, d);
    @(negedge clock);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_op     = 2'(op);
    req_shamt  = 4'(n);
    req_data   = d;
    resp_ready = (stall == 0);
    @(negedge clock);
    req_valid = 1'b0;
    check("pass1_resp_valid", 32'(resp_valid), 32'd0);
    check("pass1_sh_shamt", 32'(sh_shamt), 32'(n));
    check("pass1_sh_in", 32'(sh_in), 32'((op == 1) ? rev16(d) : d));
    if (lat == 3) begin
      @(negedge clock);
      check("pass2_resp_valid", 32'(resp_valid), 32'd0);
      check("pass2_sh_shamt", 32'(sh_shamt), 32'(16 - n));
      check("pass2_sh_in", 32'(sh_in), 32'(rev16(d)));
    end
    @(negedge clock);
    check("done_resp_valid", 32'(resp_valid), 32'd1);
    check("done_resp_data", 32'(resp_data), 32'(exp_res));
    check("done_resp_err", 32'(resp_err), 32'(op == 3));
    check("done_req_ready", 32'(req_ready), 32'd0);
    check("done_sh_shamt", 32'(sh_shamt), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      check("stall_resp_valid", 32'(resp_valid), 32'd1);
      check("stall_resp_data", 32'(resp_data), 32'(exp_res));
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    check("release_resp_valid", 32'(resp_valid), 32'd0);
    check("release_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_shamt  = 4'd0;
    req_data   = 16'd0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_sh_shamt", 32'(sh_shamt), 32'd0);
    check("rst_sh_in", 32'(sh_in), 32'd0);
    reset = 1'b1;

    run_op(0, 4, 16'h0001, 0);
    run_op(1, 15, 16'h8000, 0);
    run_op(1, 4, 16'hF0F0, 0);
    run_op(2, 1, 16'h8001, 0);
    run_op(2, 0, 16'h1234, 0);
    run_op(2, 8, 16'h1234, 5);
    run_op(3, 2, 16'h0003, 0);
    run_op(0, 2, 16'h0003, 0);
    run_op(1, 0, 16'hBEEF, 1);
    run_op(2, 15, 16'h0001, 0);

    // Reset during the second ROL pass drops the op entirely.
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = 2'd2;
    req_shamt = 4'd8;
    req_data  = 16'hABCD;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check("midrst_pass2_shamt", 32'(sh_shamt), 32'd8);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_sh_shamt", 32'(sh_shamt), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_resp_data", 32'(resp_data), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("midrst_no_resp", 32'(resp_valid), 32'd0);
    end

    for (int k = 0; k < 40; k++) begin
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
